qed_replay_buffer: RTL and testbench
====================================

QED_REPLAY_BUFFER -- requirements
Module: qed_replay_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of instruction entries (power of two, minimum 2).
REQ-002 The block SHALL have parameter AW, default 4, meaning the pointer width, equal to log2(DEPTH).
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-005 Port ifu_instruction  input  32  carries the fetched original OR1K instruction.
REQ-006 Port ifu_valid  input  1  qualifies ifu_instruction.
REQ-007 Port ifu_ready  output  1  indicates that the block accepts ifu_instruction this cycle.
REQ-008 Port qed_exec_dup  input  1  is the controller request to enter duplicate replay.
REQ-009 Port stall  input  1  is the downstream pipeline stall; while high, the decoder does not consume.
REQ-010 Port ifu_qed_instruction  output  32  is the registered instruction sent to the decoder/modifier stage.
REQ-011 Port qed_valid  output  1  qualifies ifu_qed_instruction.
REQ-012 Port qed_dup  output  1  is high when ifu_qed_instruction is a replayed duplicate.
REQ-013 Port dup_done  output  1  is a one-cycle pulse marking the end of replay.
REQ-014 Port buf_full  output  1  indicates count==DEPTH.
REQ-015 Port buf_empty  output  1  indicates count==0.
REQ-016 Port count  output  AW+1  holds the number of stored entries, 0..DEPTH.

Function
REQ-017 The FSM SHALL have exactly three states: ORIG, DUP and DONE.
REQ-018 ifu_ready SHALL be combinational: (state==ORIG) & !buf_full & !stall & !qed_exec_dup.
REQ-019 In ORIG, on ifu_valid & ifu_ready, the block SHALL set ifu_qed_instruction<=ifu_instruction, qed_valid<=1 and qed_dup<=0, and write the instruction at wr_ptr (wr_ptr+1, count+1), all in the same edge; output latency is 1 cycle.
REQ-020 In ORIG with no accept and !stall, the block SHALL set qed_valid<=0.
REQ-021 While stall=1 in any state, ifu_qed_instruction, qed_valid, qed_dup, the pointers, count and the FSM state SHALL hold.
REQ-022 ORIG->DUP SHALL occur when qed_exec_dup=1 & !stall; no instruction is accepted in that cycle.
REQ-023 In DUP with !stall and !buf_empty, the block SHALL set ifu_qed_instruction<=entry[rd_ptr], qed_valid<=1 and qed_dup<=1, and perform rd_ptr+1 and count-1.
REQ-024 Replay order SHALL equal capture order.
REQ-025 DUP->DONE SHALL occur on the edge that pops the last entry (count 1->0), or on the first non-stalled DUP cycle if the buffer is already empty.
REQ-026 In DONE, the block SHALL hold dup_done=1 for exactly one cycle and set qed_valid<=0; DONE->ORIG SHALL follow unconditionally on the next edge, and stall SHALL NOT extend DONE.
REQ-027 If qed_exec_dup is still high in ORIG after DONE, the block SHALL re-enter DUP, replaying an empty buffer and producing a further dup_done.
REQ-028 Deassertion of qed_exec_dup during DUP SHALL be ignored, and replay SHALL complete.
REQ-029 Both pointers SHALL wrap modulo DEPTH.
REQ-030 count SHALL never exceed DEPTH nor underflow; a push while full SHALL be impossible because ifu_ready=0.
REQ-031 Entry storage SHALL need no reset; only pointers, count, state and outputs are reset.

Reset
REQ-032 While rst_n=0, the block SHALL force state=ORIG, wr_ptr=0, rd_ptr=0, count=0, ifu_qed_instruction=32'h0, qed_valid=0, qed_dup=0 and dup_done=0, so that buf_empty=1 and buf_full=0.
REQ-033 Reset asserted mid-replay SHALL discard all stored entries, and the block SHALL emit no dup_done.
REQ-034 After rst_n rises, the block SHALL accept instructions on the first edge if the acceptance conditions hold.

Verification
REQ-035 Scenario: push 3 instructions 32'hE0000000, 32'hE0210000, 32'hE0420000 in ORIG, then raise qed_exec_dup -> the output shows the 3 originals with qed_dup=0, then the same 3 in order with qed_dup=1, then dup_done for 1 cycle; count ends at 0.
REQ-036 Scenario: push 16 instructions with DEPTH=16 -> buf_full=1 and ifu_ready=0; a 17th ifu_valid is not accepted; replay yields all 16, and pointers wrap to 0.
REQ-037 Scenario: raise stall for 4 cycles during replay after entry 2 -> the output holds entry 2 and count holds; the remaining entries follow with no loss or duplication.
REQ-038 Scenario: raise qed_exec_dup with an empty buffer -> DUP is entered, dup_done pulses 2 cycles later, and qed_valid stays 0.
REQ-039 Scenario: pulse rst_n low asynchronously during DUP with count=5 -> outputs go to 0 immediately, count=0, and no dup_done occurs.
REQ-040 Scenario: assert ifu_valid and qed_exec_dup in the same ORIG cycle -> the instruction is not accepted (ifu_ready=0), and replay contains only previously stored entries.

Source files
------------

// File: rtl/qed_replay_buffer.sv
// Replay buffer for QED: forwards fetched instructions to the decoder while capturing
// them, then replays the captured sequence as duplicates on controller request.
module qed_replay_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   ifu_instruction,
    input  logic          ifu_valid,
    output logic          ifu_ready,
    input  logic          qed_exec_dup,
    input  logic          stall,
    output logic [31:0]   ifu_qed_instruction,
    output logic          qed_valid,
    output logic          qed_dup,
    output logic          dup_done,
    output logic          buf_full,
    output logic          buf_empty,
    output logic [AW:0]   count
);

    typedef enum logic [1:0] {
        StOrig,
        StDup,
        StDone
    } state_e;

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] LP_ONE   = (AW+1)'(1);

    state_e         r_state;
    state_e         w_state_nxt;
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  w_wr_ptr_nxt;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW-1:0]  w_rd_ptr_nxt;
    logic [AW:0]    r_count;
    logic [AW:0]    w_count_nxt;
    logic [31:0]    r_qed_instr;
    logic [31:0]    w_qed_instr_nxt;
    logic           r_qed_valid;
    logic           w_qed_valid_nxt;
    logic           r_qed_dup;
    logic           w_qed_dup_nxt;
    logic           r_dup_done;
    logic           w_dup_done_nxt;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic           w_ifu_ready;

    // Entry storage carries no reset; validity is tracked by the pointers and count.
    logic [31:0]    r_mem [DEPTH];

    assign w_full      = (r_count == LP_DEPTH);
    assign w_empty     = (r_count == '0);
    assign w_ifu_ready = (r_state == StOrig) & ~w_full & ~stall & ~qed_exec_dup;

    always_comb begin
        w_state_nxt     = r_state;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_count_nxt     = r_count;
        w_qed_instr_nxt = r_qed_instr;
        w_qed_valid_nxt = r_qed_valid;
        w_qed_dup_nxt   = r_qed_dup;
        w_dup_done_nxt  = 1'b0;
        w_push          = 1'b0;
        w_pop           = 1'b0;

        unique case (r_state)
            StOrig: begin
                if (!stall) begin
                    if (qed_exec_dup) begin
                        w_state_nxt     = StDup;
                        w_qed_valid_nxt = 1'b0;
                    end else if (ifu_valid && w_ifu_ready) begin
                        w_push          = 1'b1;
                        w_qed_instr_nxt = ifu_instruction;
                        w_qed_valid_nxt = 1'b1;
                        w_qed_dup_nxt   = 1'b0;
                    end else begin
                        w_qed_valid_nxt = 1'b0;
                    end
                end
            end
            StDup: begin
                if (!stall) begin
                    if (!w_empty) begin
                        w_pop           = 1'b1;
                        w_qed_instr_nxt = r_mem[r_rd_ptr];
                        w_qed_valid_nxt = 1'b1;
                        w_qed_dup_nxt   = 1'b1;
                        if (r_count == LP_ONE) begin
                            w_state_nxt    = StDone;
                            w_dup_done_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt     = StDone;
                        w_dup_done_nxt  = 1'b1;
                        w_qed_valid_nxt = 1'b0;
                    end
                end
            end
            StDone: begin
                // DONE always lasts one cycle; a stall only keeps the last output visible.
                w_state_nxt = StOrig;
                if (!stall) begin
                    w_qed_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = StOrig;
            end
        endcase

        if (w_push) begin
            w_wr_ptr_nxt = r_wr_ptr + AW'(1);
            w_count_nxt  = r_count + LP_ONE;
        end
        if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + AW'(1);
            w_count_nxt  = r_count - LP_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StOrig;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_qed_instr <= 32'h0;
            r_qed_valid <= 1'b0;
            r_qed_dup   <= 1'b0;
            r_dup_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_qed_instr <= w_qed_instr_nxt;
            r_qed_valid <= w_qed_valid_nxt;
            r_qed_dup   <= w_qed_dup_nxt;
            r_dup_done  <= w_dup_done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ifu_instruction;
        end
    end

    assign ifu_ready           = w_ifu_ready;
    assign ifu_qed_instruction = r_qed_instr;
    assign qed_valid           = r_qed_valid;
    assign qed_dup             = r_qed_dup;
    assign dup_done            = r_dup_done;
    assign buf_full            = w_full;
    assign buf_empty           = w_empty;
    assign count               = r_count;

endmodule

// File: tb/tb_qed_replay_buffer.sv
// Directed bench for qed_replay_buffer: a scoreboard queue holds every output the
// bench expects, filled when stimulus is driven and drained as outputs appear.
module tb_qed_replay_buffer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic        dup;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [31:0]   ifu_instruction;
    logic          ifu_valid;
    logic          ifu_ready;
    logic          qed_exec_dup;
    logic          stall;
    logic [31:0]   ifu_qed_instruction;
    logic          qed_valid;
    logic          qed_dup;
    logic          dup_done;
    logic          buf_full;
    logic          buf_empty;
    logic [AW:0]   count;

    exp_t          exp_q[$];
    logic [31:0]   stored[$];
    int            n_tests;
    int            n_fail;
    int            n_done;

    qed_replay_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ifu_instruction     (ifu_instruction),
        .ifu_valid           (ifu_valid),
        .ifu_ready           (ifu_ready),
        .qed_exec_dup        (qed_exec_dup),
        .stall               (stall),
        .ifu_qed_instruction (ifu_qed_instruction),
        .qed_valid           (qed_valid),
        .qed_dup             (qed_dup),
        .dup_done            (dup_done),
        .buf_full            (buf_full),
        .buf_empty           (buf_empty),
        .count               (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no end of test, expected $finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; a fresh output exists only if the edge it came from was not stalled.
    task automatic tick();
        logic s;
        exp_t e;
        s = stall;
        @(posedge clk);
        #1;
        if (dup_done === 1'b1) n_done++;
        if (qed_valid === 1'b1 && !s) begin
            chk("output_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_instr", ifu_qed_instruction, e.instr);
                chk("out_dup", 32'(qed_dup), 32'(e.dup));
            end
        end
    endtask

    task automatic push(input logic [31:0] instr);
        ifu_valid       = 1'b1;
        ifu_instruction = instr;
        exp_q.push_back('{instr: instr, dup: 1'b0});
        stored.push_back(instr);
        tick();
        ifu_valid = 1'b0;
    endtask

    task automatic start_replay();
        while (stored.size() > 0) exp_q.push_back('{instr: stored.pop_front(), dup: 1'b1});
        qed_exec_dup = 1'b1;
        tick();
        qed_exec_dup = 1'b0;
    endtask

    task automatic finish_replay(input int budget);
        int got;
        int done_before;
        got = 0;
        done_before = n_done;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (dup_done === 1'b1) begin
                got = 1;
                break;
            end
        end
        chk("dup_done_seen", 32'(got), 32'd1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("count_after_replay", 32'(count), 32'd0);
        tick();
        chk("dup_done_one_cycle", 32'(dup_done), 32'd0);
        chk("valid_after_done", 32'(qed_valid), 32'd0);
        chk("single_done_pulse", 32'(n_done - done_before), 32'd1);
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        n_done          = 0;
        rst_n           = 1'b0;
        ifu_instruction = 32'h0;
        ifu_valid       = 1'b0;
        qed_exec_dup    = 1'b0;
        stall           = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(buf_empty), 32'd1);
        chk("rst_full", 32'(buf_full), 32'd0);
        chk("rst_valid", 32'(qed_valid), 32'd0);
        chk("rst_instr", ifu_qed_instruction, 32'h0);
        chk("rst_dup", 32'(qed_dup), 32'd0);
        chk("rst_done", 32'(dup_done), 32'd0);
        chk("rst_ready", 32'(ifu_ready), 32'd1);
        rst_n = 1'b1;

        // Basic capture then replay of three instructions.
        push(32'hE000_0000);
        push(32'hE021_0000);
        push(32'hE042_0000);
        chk("count_3", 32'(count), 32'd3);
        start_replay();
        chk("valid_on_dup_entry", 32'(qed_valid), 32'd0);
        finish_replay(10);

        // Concurrent valid and replay request: the new instruction must be refused.
        push(32'hA000_0001);
        push(32'hA000_0002);
        ifu_valid       = 1'b1;
        ifu_instruction = 32'hBAD0_0BAD;
        qed_exec_dup    = 1'b1;
        #1;
        chk("ready_low_on_dup_req", 32'(ifu_ready), 32'd0);
        ifu_valid    = 1'b0;
        qed_exec_dup = 1'b0;
        start_replay();
        finish_replay(10);

        // Replay of an empty buffer: DONE two edges after the request, no valid output.
        start_replay();
        chk("empty_dup_valid", 32'(qed_valid), 32'd0);
        tick();
        chk("empty_dup_done", 32'(dup_done), 32'd1);
        chk("empty_dup_valid2", 32'(qed_valid), 32'd0);
        tick();
        chk("empty_dup_done_clr", 32'(dup_done), 32'd0);

        // Fill to DEPTH, try a 17th, then replay all.
        for (int i = 0; i < DEPTH; i++) push(32'h1000_0000 + 32'(i));
        chk("full_flag", 32'(buf_full), 32'd1);
        chk("count_full", 32'(count), 32'(DEPTH));
        ifu_valid       = 1'b1;
        ifu_instruction = 32'hDEAD_BEEF;
        #1;
        chk("ready_when_full", 32'(ifu_ready), 32'd0);
        tick();
        ifu_valid = 1'b0;
        chk("count_no_overflow", 32'(count), 32'(DEPTH));
        start_replay();
        finish_replay(DEPTH + 4);

        // Stall for four cycles mid-replay; output and count must hold.
        for (int i = 0; i < 5; i++) push(32'h2000_0000 + 32'(i));
        start_replay();
        tick();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_hold_instr", ifu_qed_instruction, 32'h2000_0001);
            chk("stall_hold_valid", 32'(qed_valid), 32'd1);
            chk("stall_hold_count", 32'(count), 32'd3);
        end
        stall = 1'b0;
        finish_replay(10);

        // Asynchronous reset mid-replay with five entries left.
        for (int i = 0; i < 6; i++) push(32'h3000_0000 + 32'(i));
        start_replay();
        tick();
        chk("count_before_rst", 32'(count), 32'd5);
        n_done = 0;
        rst_n  = 1'b0;
        #2;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(qed_valid), 32'd0);
        chk("arst_instr", ifu_qed_instruction, 32'h0);
        chk("arst_empty", 32'(buf_empty), 32'd1);
        exp_q.delete();
        stored.delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("no_done_after_rst", 32'(n_done), 32'd0);

        // First edge after reset accepts immediately.
        push(32'h4000_0042);
        chk("post_rst_count", 32'(count), 32'd1);
        start_replay();
        finish_replay(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
